// File: rtl/hc165_key_reader.sv
// Scans a 74HC165 chain into a parallel key vector, debounces it across frames and
// emits one-cycle press/release pulses for every key whose debounced state changes.
module hc165_key_reader #(
  parameter int DATA_WIDTH     = 8,
  parameter int CLK_DIV_PERIOD = 600,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int SCAN_GAP       = 16,
  parameter int ACTIVE_LOW     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  pl_n_out,
  output logic                  sclk_out,
  input  logic                  sdio_in,
  output logic [DATA_WIDTH-1:0] key_raw,
  output logic                  frame_done,
  output logic [DATA_WIDTH-1:0] key_state,
  output logic [DATA_WIDTH-1:0] key_press,
  output logic [DATA_WIDTH-1:0] key_release
);

  localparam int DIV_W = $clog2(CLK_DIV_PERIOD);
  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV_PERIOD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);
  localparam logic [7:0]       GAP_LAST = 8'((SCAN_GAP > 0) ? SCAN_GAP - 1 : 0);
  localparam logic [3:0]       DB_MIN   = 4'(DEBOUNCE_SCANS);
  localparam logic [DATA_WIDTH-1:0] POL_MASK =
    (ACTIVE_LOW != 0) ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE, S_GAP} state_t;

  logic [DIV_W-1:0]      div_q;
  logic                  tick_q;
  state_t                state_q, state_d;
  logic                  load_ph_q, load_ph_d;
  logic                  half_q, half_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [7:0]            gap_q, gap_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  pl_n_q, pl_n_d;
  logic                  sclk_q, sclk_d;
  logic [DATA_WIDTH-1:0] key_raw_q, key_raw_d;
  logic                  frame_done_q, frame_done_d;
  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic [3:0]            match_q, match_d;
  logic [3:0]            match_upd;
  logic [DATA_WIDTH-1:0] key_state_q, key_state_d;
  logic [DATA_WIDTH-1:0] key_press_q, key_press_d;
  logic [DATA_WIDTH-1:0] key_release_q, key_release_d;

  // Free-running divider; tick is registered so it lands one clk after the wrap count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      tick_q <= (div_q == DIV_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      load_ph_q    <= 1'b0;
      half_q       <= 1'b0;
      idx_q        <= '0;
      gap_q        <= '0;
      shift_q      <= '0;
      pl_n_q       <= 1'b1;
      sclk_q       <= 1'b0;
      key_raw_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_ph_q    <= load_ph_d;
      half_q       <= half_d;
      idx_q        <= idx_d;
      gap_q        <= gap_d;
      shift_q      <= shift_d;
      pl_n_q       <= pl_n_d;
      sclk_q       <= sclk_d;
      key_raw_q    <= key_raw_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    load_ph_d    = load_ph_q;
    half_d       = half_q;
    idx_d        = idx_q;
    gap_d        = gap_q;
    shift_d      = shift_q;
    pl_n_d       = pl_n_q;
    sclk_d       = sclk_q;
    key_raw_d    = key_raw_q;
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        load_ph_d = 1'b0;
        state_d   = S_LOAD;
      end
      S_LOAD: if (tick_q) begin
        if (!load_ph_q) begin
          pl_n_d    = 1'b0;
          sclk_d    = 1'b0;
          load_ph_d = 1'b1;
        end else begin
          pl_n_d  = 1'b1;
          idx_d   = '0;
          half_d  = 1'b0;
          state_d = S_SHIFT;
        end
      end
      // Sample QH while sclk is low, then raise sclk to advance the chain.
      S_SHIFT: if (tick_q) begin
        if (!half_q) begin
          sclk_d  = 1'b0;
          shift_d = {shift_q[DATA_WIDTH-2:0], sdio_in};
          half_d  = 1'b1;
        end else begin
          sclk_d = 1'b1;
          half_d = 1'b0;
          if (idx_q == IDX_LAST) state_d = S_DONE;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      S_DONE: if (tick_q) begin
        sclk_d       = 1'b0;
        key_raw_d    = shift_q ^ POL_MASK;
        frame_done_d = 1'b1;
        gap_d        = '0;
        load_ph_d    = 1'b0;
        state_d      = (SCAN_GAP == 0) ? S_LOAD : S_GAP;
      end
      S_GAP: if (tick_q) begin
        if (gap_q == GAP_LAST) begin
          load_ph_d = 1'b0;
          state_d   = S_LOAD;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Debounce runs in the frame_done clk; a change becomes visible one clk later.
  always_comb begin
    if (key_raw_q == prev_q) match_upd = (match_q == 4'd15) ? 4'd15 : match_q + 4'd1;
    else                     match_upd = 4'd1;
  end

  always_comb begin
    prev_d        = prev_q;
    match_d       = match_q;
    key_state_d   = key_state_q;
    key_press_d   = '0;
    key_release_d = '0;
    if (frame_done_q) begin
      prev_d  = key_raw_q;
      match_d = match_upd;
      if (match_upd >= DB_MIN && key_raw_q != key_state_q) begin
        key_state_d   = key_raw_q;
        key_press_d   = key_raw_q & ~key_state_q;
        key_release_d = ~key_raw_q & key_state_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q        <= '0;
      match_q       <= '0;
      key_state_q   <= '0;
      key_press_q   <= '0;
      key_release_q <= '0;
    end else begin
      prev_q        <= prev_d;
      match_q       <= match_d;
      key_state_q   <= key_state_d;
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
    end
  end

  assign pl_n_out    = pl_n_q;
  assign sclk_out    = sclk_q;
  assign key_raw     = key_raw_q;
  assign frame_done  = frame_done_q;
  assign key_state   = key_state_q;
  assign key_press   = key_press_q;
  assign key_release = key_release_q;

endmodule

// File: tb/tb_hc165_key_reader.sv
// Two reader instances driven by behavioural 74HC165 chains: an 8-bit active-high
// chain with random frames, and a 16-bit active-low chain exercising debounce and reset.
module tb_hc165_key_reader;
  localparam int P     = 4;
  localparam int PER_A = (2 * 8 + 3 + 0) * P;
  localparam int PER_B = (2 * 16 + 3 + 2) * P;
  localparam int DB_B  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n = 1'b0, rst_b_n = 1'b0;
  logic pl_a, sclk_a, sdio_a, fd_a;
  logic [7:0] raw_a, st_a, pr_a, rl_a;
  logic pl_b, sclk_b, sdio_b, fd_b;
  logic [15:0] raw_b, st_b, pr_b, rl_b;

  hc165_key_reader #(.DATA_WIDTH(8), .CLK_DIV_PERIOD(P), .DEBOUNCE_SCANS(1),
                     .SCAN_GAP(0), .ACTIVE_LOW(0)) u_a (
    .clk(clk), .rst_n(rst_a_n), .pl_n_out(pl_a), .sclk_out(sclk_a), .sdio_in(sdio_a),
    .key_raw(raw_a), .frame_done(fd_a), .key_state(st_a), .key_press(pr_a),
    .key_release(rl_a));

  hc165_key_reader #(.DATA_WIDTH(16), .CLK_DIV_PERIOD(P), .DEBOUNCE_SCANS(DB_B),
                     .SCAN_GAP(2), .ACTIVE_LOW(1)) u_b (
    .clk(clk), .rst_n(rst_b_n), .pl_n_out(pl_b), .sclk_out(sclk_b), .sdio_in(sdio_b),
    .key_raw(raw_b), .frame_done(fd_b), .key_state(st_b), .key_press(pr_b),
    .key_release(rl_b));

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural 74HC165 chains: transparent load while SH/LD low, shift on CLK rise.
  logic [7:0]  pins_a = '0, hc_a = '0;
  logic [15:0] pins_b = '0, hc_b = '0;
  logic hs_a = 1'b0, hs_b = 1'b0;
  assign sdio_a = hc_a[7];
  assign sdio_b = hc_b[15];

  initial forever begin
    @(negedge clk);
    if (!pl_a) hc_a = pins_a;
    else if (sclk_a && !hs_a) hc_a = {hc_a[6:0], 1'b0};
    hs_a = sclk_a;
    if (!pl_b) hc_b = pins_b;
    else if (sclk_b && !hs_b) hc_b = {hc_b[14:0], 1'b0};
    hs_b = sclk_b;
  end

  // Feeders: each load picks the pins for that frame and queues the expected frame.
  logic [7:0]  exp_a[$];
  logic [15:0] exp_b[$], plan_b[$];
  int nload_a = 0;

  initial forever begin
    @(negedge pl_a);
    pins_a = (nload_a < 4) ? 8'hA5 : 8'($urandom);
    nload_a++;
    exp_a.push_back(pins_a);
  end

  initial forever begin
    @(negedge pl_b);
    if (plan_b.size() > 0) pins_b = plan_b.pop_front();
    exp_b.push_back(~pins_b);
  end

  // Monitor A: every frame is accepted immediately (single-scan debounce).
  logic [7:0] ref_a = '0, pp_a = '0, prl_a = '0, new_a;
  logic pend_a = 1'b0, sp_a = 1'b0, seen_a = 1'b0;
  int cyc_a = 0, rise_a = 0, pll_a = 0;

  initial forever begin
    @(negedge clk);
    if (!rst_a_n) begin
      ref_a = '0; pend_a = 0; seen_a = 0; cyc_a = 0; rise_a = 0; pll_a = 0; sp_a = 0;
    end else begin
      cyc_a++;
      if (pend_a) begin
        chk("A_key_state", st_a, ref_a);
        chk("A_press_release", {pr_a, rl_a}, {pp_a, prl_a});
        pend_a = 0;
      end else if ((pr_a | rl_a) != 0) chk("A_stray_pulse", {pr_a, rl_a}, 0);
      if (sclk_a && !sp_a) rise_a++;
      sp_a = sclk_a;
      if (!pl_a) pll_a++;
      else if (pll_a > 0) begin chk("A_pl_low_clks", pll_a, P); pll_a = 0; end
      if (fd_a) begin
        if (exp_a.size() == 0) chk("A_unexpected_frame", 1, 0);
        else begin
          new_a = exp_a.pop_front();
          chk("A_key_raw", raw_a, new_a);
          pp_a = new_a & ~ref_a; prl_a = ~new_a & ref_a; ref_a = new_a; pend_a = 1;
        end
        chk("A_sclk_rises", rise_a, 8);
        rise_a = 0;
        if (seen_a) chk("A_frame_period", cyc_a, PER_A);
        cyc_a = 0; seen_a = 1;
      end
    end
  end

  // Monitor B: debounced state follows a frame once it has repeated DB_B times in a row.
  logic [15:0] hist_b[$];
  logic [15:0] ref_b = '0, pp_b = '0, prl_b = '0, new_b, nref_b;
  logic [15:0] last_pr_b = '0, last_rl_b = '0;
  logic pend_b = 1'b0, sp_b = 1'b0, seen_b = 1'b0, any_pulse_b = 1'b0;
  int cyc_b = 0, rise_b = 0, pll_b = 0, nfr_b = 0, run_b;

  initial forever begin
    @(negedge clk);
    if (!rst_b_n) begin
      hist_b.delete();
      ref_b = '0; pend_b = 0; seen_b = 0; cyc_b = 0; rise_b = 0; pll_b = 0; sp_b = 0;
    end else begin
      cyc_b++;
      if (pend_b) begin
        chk("B_key_state", st_b, ref_b);
        chk("B_press_release", {pr_b, rl_b}, {pp_b, prl_b});
        pend_b = 0;
      end else if ((pr_b | rl_b) != 0) chk("B_stray_pulse", {pr_b, rl_b}, 0);
      if ((pr_b | rl_b) != 0) begin any_pulse_b = 1; last_pr_b = pr_b; last_rl_b = rl_b; end
      if (sclk_b && !sp_b) rise_b++;
      sp_b = sclk_b;
      if (!pl_b) pll_b++;
      else if (pll_b > 0) begin chk("B_pl_low_clks", pll_b, P); pll_b = 0; end
      if (fd_b) begin
        if (exp_b.size() == 0) chk("B_unexpected_frame", 1, 0);
        else begin
          new_b = exp_b.pop_front();
          chk("B_key_raw", raw_b, new_b);
          chk("B_state_latency", st_b, ref_b);
          hist_b.push_back(new_b);
          run_b = 0;
          for (int i = hist_b.size() - 1; i >= 0; i--) begin
            if (hist_b[i] != new_b) break;
            run_b++;
          end
          if (run_b > 15) run_b = 15;
          nref_b = (run_b >= DB_B) ? new_b : ref_b;
          pp_b = nref_b & ~ref_b; prl_b = ~nref_b & ref_b; ref_b = nref_b; pend_b = 1;
        end
        chk("B_sclk_rises", rise_b, 16);
        rise_b = 0;
        if (seen_b) chk("B_frame_period", cyc_b, PER_B);
        cyc_b = 0; seen_b = 1;
        nfr_b++;
      end
    end
  end

  task automatic wait_fr_b(input int tgt);
    int n = 0;
    while (nfr_b < tgt && n < 20000) begin @(negedge clk); n++; end
    if (nfr_b < tgt) chk("B_frame_timeout", nfr_b, tgt);
    repeat (2) @(negedge clk);
  endtask

  initial begin : main
    logic [15:0] v;
    int n, r;
    logic prev;
    for (int i = 0; i < 10; i++) plan_b.push_back((i % 2 == 0) ? 16'hFFFE : 16'hFFFF);
    repeat (3) plan_b.push_back(16'hFFFE);
    repeat (3) plan_b.push_back(16'hFFFD);
    v = 16'hFFFD;
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 3) == 0) v = 16'($urandom);
      plan_b.push_back(v);
    end

    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("A_reset_ctl", {pl_a, sclk_a, fd_a}, 3'b100);
    chk("A_reset_vec", {raw_a, st_a, pr_a, rl_a}, 0);
    chk("B_reset_ctl", {pl_b, sclk_b, fd_b}, 3'b100);
    chk("B_reset_raw_state", {raw_b, st_b}, 0);
    chk("B_reset_pulses", {pr_b, rl_b}, 0);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    n = 0;
    while (pl_a && n < P + 8) begin @(negedge clk); n++; end
    chk("A_first_load_within_bound", (n <= P + 2) ? 1 : 0, 1);

    wait_fr_b(10);
    chk("B_bounce_state", st_b, 16'h0000);
    chk("B_bounce_pulses", any_pulse_b, 0);
    wait_fr_b(12);
    chk("B_two_scans_state", st_b, 16'h0000);
    wait_fr_b(13);
    chk("B_accept_state", st_b, 16'h0001);
    chk("B_accept_press", {last_pr_b, last_rl_b}, {16'h0001, 16'h0000});
    wait_fr_b(16);
    chk("B_swap_state", st_b, 16'h0002);
    chk("B_swap_pulses", {last_pr_b, last_rl_b}, {16'h0002, 16'h0001});
    wait_fr_b(32);

    plan_b.push_back(16'hBEEF);
    n = 0;
    while (pl_b && n < 400) begin @(negedge clk); n++; end
    chk("B_midframe_load_seen", pl_b, 1'b0);
    n = 0; r = 0; prev = sclk_b;
    while (r < 5 && n < 800) begin
      @(negedge clk); n++;
      if (sclk_b && !prev) r++;
      prev = sclk_b;
    end
    chk("B_reached_bit5", r, 5);
    @(posedge clk);
    #1 rst_b_n = 1'b0;
    if (exp_b.size() > 0) exp_b.delete(exp_b.size() - 1);
    repeat (3) @(negedge clk);
    chk("B_midreset_ctl", {pl_b, sclk_b, fd_b}, 3'b100);
    chk("B_midreset_raw_state", {raw_b, st_b}, 0);
    chk("B_midreset_pulses", {pr_b, rl_b}, 0);
    @(posedge clk);
    #1 rst_b_n = 1'b1;
    wait_fr_b(33);
    chk("B_fresh_frame_raw", raw_b, 16'h4110);
    chk("B_fresh_frame_state", st_b, 16'h0000);

    repeat (20) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
